// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory port, redirect input, decode handshake, fault and state debug.
// The fetch unit connects through the master modport; memory/execute/decode side uses slave.
interface instruction_fetch_unit_if;
    logic [15:0] PCAddress;
    logic [15:0] Instruction;
    logic        FetchEnable;
    logic        RedirectValid;
    logic [15:0] RedirectTarget;
    logic [15:0] InstrOut;
    logic [15:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady;
    logic        FetchFault;
    logic [1:0]  FetchState;

    modport master (
        output PCAddress, InstrOut, InstrPC, InstrValid, FetchFault, FetchState,
        input  Instruction, FetchEnable, RedirectValid, RedirectTarget, InstrReady
    );

    modport slave (
        input  PCAddress, InstrOut, InstrPC, InstrValid, FetchFault, FetchState,
        output Instruction, FetchEnable, RedirectValid, RedirectTarget, InstrReady
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: fetch PC, 2-entry instruction queue, redirect flush.
// Optional bounds/alignment fault logic is enabled by defining FETCH_BOUNDS_CHECK_EN.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          MEM_BYTES = 128
) (
    input  logic Clock,
    input  logic Reset,
    instruction_fetch_unit_if.master bus
);

    // Decode handshake: an entry transfers on a rising edge where InstrValid && InstrReady;
    // InstrValid never depends on InstrReady, and a redirect in that cycle cancels the transfer.

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [15:0] LAST_PC = 16'(MEM_BYTES - 2);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    state_t      state;
    logic [15:0] pc;
    logic [15:0] q_instr [2];
    logic [15:0] q_pc    [2];
    logic        head;
    logic [1:0]  count;
    logic        fault;

    logic        pop;
    logic        has_space;
    logic        fetch_try;
    logic        pc_bad;
    logic        do_push;
    logic        tail;
    logic [15:0] target;
`ifdef FETCH_BOUNDS_CHECK_EN
    logic        target_legal;
`endif

    always_comb begin
        pop       = (count != 2'd0) && bus.InstrReady;
        has_space = (count != 2'd2) || pop;
        fetch_try = (state == RUN) && bus.FetchEnable && has_space;
        tail      = head ^ count[0];
`ifdef FETCH_BOUNDS_CHECK_EN
        pc_bad       = (pc > LAST_PC) || pc[0];
        target       = bus.RedirectTarget;
        target_legal = !((target > LAST_PC) || target[0]);
`else
        pc_bad = 1'b0;
        // Without checks, targets are forced halfword-aligned.
        target = {bus.RedirectTarget[15:1], bus.RedirectTarget[0] & 1'b0};
`endif
        do_push = fetch_try && !pc_bad;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            head  <= 1'b0;
            count <= 2'd0;
            fault <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_instr[i] <= 16'h0000;
                q_pc[i]    <= 16'h0000;
            end
        end else if (bus.RedirectValid) begin
            // Redirect wins over push and pop: flush everything, reload PC.
            pc    <= target;
            count <= 2'd0;
`ifdef FETCH_BOUNDS_CHECK_EN
            if (target_legal) begin
                fault <= 1'b0;
                state <= bus.FetchEnable ? RUN : IDLE;
            end else if (state != FAULT) begin
                // An illegal target is loaded and faults when fetch is attempted.
                state <= bus.FetchEnable ? RUN : IDLE;
            end
`else
            state <= bus.FetchEnable ? RUN : IDLE;
`endif
        end else begin
            case (state)
                IDLE: if (bus.FetchEnable) state <= RUN;
                RUN: begin
                    if (!bus.FetchEnable) begin
                        state <= IDLE;
`ifdef FETCH_BOUNDS_CHECK_EN
                    end else if (fetch_try && pc_bad) begin
                        state <= FAULT;
                        fault <= 1'b1;
`endif
                    end
                end
`ifdef FETCH_BOUNDS_CHECK_EN
                FAULT: state <= FAULT;
`endif
                default: state <= IDLE;
            endcase

            if (do_push) begin
                q_instr[tail] <= bus.Instruction;
                q_pc[tail]    <= pc;
                pc            <= pc + 16'd2;
            end

            if (do_push && !pop) begin
                count <= count + 2'd1;
            end else if (!do_push && pop) begin
                count <= count - 2'd1;
            end

            if (pop) head <= ~head;
        end
    end

    assign bus.PCAddress  = pc;
    assign bus.InstrOut   = q_instr[head];
    assign bus.InstrPC    = q_pc[head];
    assign bus.InstrValid = (count != 2'd0);
    assign bus.FetchState = state;
`ifdef FETCH_BOUNDS_CHECK_EN
    assign bus.FetchFault = fault;
`else
    assign bus.FetchFault = fault & 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: scoreboard queue of expected {pc, instr} pairs
// checked by an independent monitor on each decode accept, plus directed output checks.
module tb_instruction_fetch_unit;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic clk;
    logic rst;
    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_PC(16'h0000), .MEM_BYTES(128)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: bytes 0..5 = 12 34 56 78 9A BC, byte i = i elsewhere.
    logic [7:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
        mem[3] = 8'h78; mem[4] = 8'h9A; mem[5] = 8'hBC;
    end
    assign bus.Instruction = {mem[bus.PCAddress[7:0]], mem[bus.PCAddress[7:0] + 8'd1]};

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [15:0] pc, input logic [15:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    task automatic redirect(input logic [15:0] tgt);
        bus.RedirectValid  = 1'b1;
        bus.RedirectTarget = tgt;
        tick();
        bus.RedirectValid  = 1'b0;
    endtask

    // Monitor: compare every accepted head against the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.InstrValid && bus.InstrReady && !bus.RedirectValid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: got pc %h instr %h expected none",
                             bus.InstrPC, bus.InstrOut);
                end else begin
                    e = exp_q.pop_front();
                    check("accept_pc_instr", {bus.InstrPC, bus.InstrOut}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.FetchEnable    = 1'b0;
        bus.RedirectValid  = 1'b0;
        bus.RedirectTarget = 16'h0000;
        bus.InstrReady     = 1'b0;
        tick();
        tick();
        check("reset_pc", {16'h0, bus.PCAddress}, 32'h0000);
        check("reset_instrout", {16'h0, bus.InstrOut}, 32'h0000);
        check("reset_instrpc", {16'h0, bus.InstrPC}, 32'h0000);
        check("reset_valid", {31'h0, bus.InstrValid}, 32'h0);
        check("reset_fault", {31'h0, bus.FetchFault}, 32'h0);
        check("reset_state", {30'h0, bus.FetchState}, {30'h0, S_IDLE});
        rst = 1'b0;

        // Streaming fetch, ready high
        bus.FetchEnable = 1'b1;
        bus.InstrReady  = 1'b1;
        expect_word(16'h0000, 16'h1234);
        expect_word(16'h0002, 16'h5678);
        expect_word(16'h0004, 16'h9ABC);
        tick();
        check("run_entry_state", {30'h0, bus.FetchState}, {30'h0, S_RUN});
        check("run_entry_valid", {31'h0, bus.InstrValid}, 32'h0);
        tick();
        check("first_word_valid", {31'h0, bus.InstrValid}, 32'h1);
        tick();
        tick();
        bus.FetchEnable = 1'b0;
        tick();
        check("stream_end_pc", {16'h0, bus.PCAddress}, 32'h0006);
        check("stream_end_valid", {31'h0, bus.InstrValid}, 32'h0);
        check("stream_end_state", {30'h0, bus.FetchState}, {30'h0, S_IDLE});

        // Back-pressure: queue fills and holds
        bus.FetchEnable = 1'b1;
        bus.InstrReady  = 1'b0;
        redirect(16'h0000);
        tick();
        tick();
        tick();
        check("full_pc_hold", {16'h0, bus.PCAddress}, 32'h0004);
        check("full_head_instr", {16'h0, bus.InstrOut}, 32'h1234);
        check("full_head_pc", {16'h0, bus.InstrPC}, 32'h0000);
        tick();
        check("full_pc_hold2", {16'h0, bus.PCAddress}, 32'h0004);
        check("full_head_hold2", {16'h0, bus.InstrOut}, 32'h1234);
        expect_word(16'h0000, 16'h1234);
        expect_word(16'h0002, 16'h5678);
        expect_word(16'h0004, 16'h9ABC);
        bus.InstrReady = 1'b1;
        tick();
        bus.FetchEnable = 1'b0;
        check("release_head1", {16'h0, bus.InstrOut}, 32'h5678);
        tick();
        check("release_head2", {16'h0, bus.InstrOut}, 32'h9ABC);
        check("release_valid2", {31'h0, bus.InstrValid}, 32'h1);
        tick();
        check("release_drained", {31'h0, bus.InstrValid}, 32'h0);

        // Redirect on a full queue in the same cycle as a pop
        bus.FetchEnable = 1'b1;
        bus.InstrReady  = 1'b0;
        redirect(16'h0000);
        tick();
        tick();
        check("pre_flush_valid", {31'h0, bus.InstrValid}, 32'h1);
        bus.InstrReady = 1'b1;
        redirect(16'h0040);
        check("flush_valid", {31'h0, bus.InstrValid}, 32'h0);
        check("flush_pc", {16'h0, bus.PCAddress}, 32'h0040);
        expect_word(16'h0040, 16'h4041);
        tick();
        bus.FetchEnable = 1'b0;
        check("target_instrpc", {16'h0, bus.InstrPC}, 32'h0040);
        check("target_valid", {31'h0, bus.InstrValid}, 32'h1);
        tick();

`ifdef FETCH_BOUNDS_CHECK_EN
        // Last legal address, then bounds fault, then recovery
        bus.FetchEnable = 1'b1;
        redirect(16'h007E);
        expect_word(16'h007E, 16'h7E7F);
        tick();
        tick();
        check("oob_fault", {31'h0, bus.FetchFault}, 32'h1);
        check("oob_pc", {16'h0, bus.PCAddress}, 32'h0080);
        check("oob_state", {30'h0, bus.FetchState}, {30'h0, S_FAULT});
        tick();
        check("oob_no_push", {31'h0, bus.InstrValid}, 32'h0);
        check("oob_fault_sticky", {31'h0, bus.FetchFault}, 32'h1);
        redirect(16'h0000);
        check("recover_fault", {31'h0, bus.FetchFault}, 32'h0);
        check("recover_state", {30'h0, bus.FetchState}, {30'h0, S_RUN});
        expect_word(16'h0000, 16'h1234);
        tick();
        bus.FetchEnable = 1'b0;
        tick();

        // Misaligned redirect target
        bus.FetchEnable = 1'b1;
        redirect(16'h0011);
        check("misalign_pc", {16'h0, bus.PCAddress}, 32'h0011);
        check("misalign_fault_pre", {31'h0, bus.FetchFault}, 32'h0);
        tick();
        check("misalign_fault", {31'h0, bus.FetchFault}, 32'h1);
        check("misalign_no_push", {31'h0, bus.InstrValid}, 32'h0);
        bus.FetchEnable = 1'b0;
        redirect(16'h0000);
        check("misalign_clear", {31'h0, bus.FetchFault}, 32'h0);
`else
        // No checks: wraps past the end and aligns redirect targets
        bus.FetchEnable = 1'b1;
        redirect(16'h007E);
        expect_word(16'h007E, 16'h7E7F);
        expect_word(16'h0080, 16'h8081);
        tick();
        tick();
        bus.FetchEnable = 1'b0;
        check("nocheck_fault", {31'h0, bus.FetchFault}, 32'h0);
        tick();
        tick();
        bus.FetchEnable = 1'b1;
        redirect(16'h0011);
        check("align_pc", {16'h0, bus.PCAddress}, 32'h0010);
        expect_word(16'h0010, 16'h1011);
        tick();
        bus.FetchEnable = 1'b0;
        tick();
        check("align_fault", {31'h0, bus.FetchFault}, 32'h0);
`endif

        // Asynchronous reset with a full queue
        bus.FetchEnable = 1'b1;
        bus.InstrReady  = 1'b0;
        redirect(16'h0000);
        tick();
        tick();
        check("prereset_valid", {31'h0, bus.InstrValid}, 32'h1);
        rst = 1'b1;
        bus.FetchEnable = 1'b0;
        #1;
        check("async_reset_pc", {16'h0, bus.PCAddress}, 32'h0000);
        check("async_reset_valid", {31'h0, bus.InstrValid}, 32'h0);
        check("async_reset_instrout", {16'h0, bus.InstrOut}, 32'h0000);
        check("async_reset_instrpc", {16'h0, bus.InstrPC}, 32'h0000);
        check("async_reset_fault", {31'h0, bus.FetchFault}, 32'h0);
        tick();
        rst = 1'b0;
        bus.FetchEnable = 1'b1;
        bus.InstrReady  = 1'b1;
        expect_word(16'h0000, 16'h1234);
        tick();
        tick();
        bus.FetchEnable = 1'b0;
        tick();
        check("restart_pc", {16'h0, bus.PCAddress}, 32'h0002);
        tick();
        tick();

        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
